// File: rtl/tick_gen_pkg.sv
// +-----------------------------------------------------------------------+
// | tick_gen_pkg: shared state encoding, limits and helpers for tick_gen   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package tick_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int MAX_CH = 16;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen_ch.sv
// +-----------------------------------------------------------------------+
// | tick_gen_ch: one tick channel (counter, shadow/active period, FSM)     |
// | Option macro: TICK_GEN_REG_OUT_EN registers tick/busy/done. Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W      = 26,
  parameter logic [CNT_W-1:0] DEF_PERIOD = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             oneshot,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] sh_next;
  logic             term;
  logic             load_act;
  logic             tick_c;
  logic             busy_c;
  logic             done_c;

  assign term     = (state == RUN) && (cnt == period_act);
  // A write landing on the wrap edge must win over the stale shadow value.
  assign sh_next  = wr ? wdata : period_sh;
  assign load_act = (wr && (state != RUN)) || (en && (sync_clr || term));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      period_sh  <= DEF_PERIOD;
      period_act <= DEF_PERIOD;
    end else begin
      if (wr)       period_sh  <= wdata;
      if (load_act) period_act <= sh_next;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (sync_clr) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= RUN;
            cnt   <= '0;
          end
          RUN: begin
            if (term) begin
              cnt   <= '0;
              state <= oneshot ? DONE : RUN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tick_c = term && !sync_clr;
  assign busy_c = (state == RUN);
  assign done_c = (state == DONE);

`ifdef TICK_GEN_REG_OUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tick <= tick_c;
      busy <= busy_c;
      done <= done_c;
    end
  end
`else
  assign tick = tick_c;
  assign busy = busy_c;
  assign done = done_c;
`endif

endmodule

`default_nettype wire

// File: rtl/tick_gen_multi.sv
// +-----------------------------------------------------------------------+
// | tick_gen_multi: NUM_CH programmable periodic/one-shot tick generator   |
// | Option macro: TICK_GEN_REG_OUT_EN registers tick/busy/done. Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      CNT_W       = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_PERIODS = {26'd999, 26'd49_999_999}
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_oneshot,
  input  logic                      sync_clr,
  input  logic                      period_wr,
  input  logic [sel_w(NUM_CH)-1:0]  period_sel,
  input  logic [CNT_W-1:0]          period_data,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  localparam int SEL_W = sel_w(NUM_CH);

  // Out-of-range selects simply match no channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_ch;
    assign wr_ch = period_wr && (period_sel == SEL_W'(i));

    tick_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIODS[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .en       (ch_en[i]),
      .oneshot  (ch_oneshot[i]),
      .sync_clr (sync_clr),
      .wr       (wr_ch),
      .wdata    (period_data),
      .tick     (tick[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_gen_multi.sv
// +-----------------------------------------------------------------------+
// | tb_tick_gen_multi: scoreboard bench for tick_gen_multi                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_tick_gen_multi;

`ifdef TICK_GEN_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  ch_en;
  logic [1:0]  ch_oneshot;
  logic        sync_clr;
  logic        period_wr;
  logic [0:0]  period_sel;
  logic [25:0] period_data;
  logic [1:0]  tick;
  logic [1:0]  busy;
  logic [1:0]  done;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit exp_tick [int];
  int c, k, k2, r;

  tick_gen_multi #(
    .NUM_CH      (2),
    .CNT_W       (26),
    .DEF_PERIODS ({26'd99, 26'd9})
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ch_en       (ch_en),
    .ch_oneshot  (ch_oneshot),
    .sync_clr    (sync_clr),
    .period_wr   (period_wr),
    .period_sel  (period_sel),
    .period_data (period_data),
    .tick        (tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // cyc == N during the cycle that follows clock edge N
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_tick(input int ch, input int t);
    exp_tick[t * 2 + ch] = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic write_period(input logic sel, input logic [25:0] data);
    period_wr   = 1'b1;
    period_sel  = sel;
    period_data = data;
    step(1);
    period_wr   = 1'b0;
  endtask

  // Monitor: every observed tick must consume a scoreboard entry for that cycle.
  always @(negedge clk) begin
    int key;
    for (int ch = 0; ch < 2; ch++) begin
      key = cyc * 2 + ch;
      if (tick[ch]) begin
        n_checks++;
        if (exp_tick.exists(key)) begin
          exp_tick.delete(key);
        end else begin
          n_fail++;
          $display("FAIL tick_unexpected ch%0d @cyc %0d: got 1 expected 0", ch, cyc);
        end
      end else if (exp_tick.exists(key)) begin
        n_checks++;
        n_fail++;
        $display("FAIL tick_missing ch%0d @cyc %0d: got 0 expected 1", ch, cyc);
        exp_tick.delete(key);
      end
    end
  end

  initial begin
    rstn = 1'b0; ch_en = 2'b00; ch_oneshot = 2'b00; sync_clr = 1'b0;
    period_wr = 1'b0; period_sel = 1'b0; period_data = '0;
    #3;
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    step(2);
    rstn = 1'b1;
    step(2);

    // Default periods: ch0 = 9, ch1 = 99
    c = cyc; ch_en = 2'b11; k = c + 1;
    for (int t = k + 9; t <= k + 204; t += 10) expect_tick(0, t + LAT);
    expect_tick(1, k + 99 + LAT);
    expect_tick(1, k + 199 + LAT);
    wait_until(k + 50);
    check("run_busy", 32'(busy), 32'h3);
    check("run_done", 32'(done), 32'h0);
    wait_until(c + 205);
    ch_en = 2'b00;
    step(2 + LAT);
    check("idle_busy", 32'(busy), 32'h0);

    // Write 4 mid-interval, then 6 on a terminal edge
    c = cyc; ch_en = 2'b01; k = c + 1;
    expect_tick(0, k + 9 + LAT);
    expect_tick(0, k + 14 + LAT);
    expect_tick(0, k + 19 + LAT);
    expect_tick(0, k + 24 + LAT);
    expect_tick(0, k + 31 + LAT);
    expect_tick(0, k + 38 + LAT);
    expect_tick(0, k + 45 + LAT);
    wait_until(k + 2);
    write_period(1'b0, 26'd4);
    wait_until(k + 24);
    write_period(1'b0, 26'd6);
    wait_until(k + 47);
    ch_en = 2'b00;
    step(3);

    // One-shot, period 3
    c = cyc;
    write_period(1'b0, 26'd3);
    ch_oneshot = 2'b01; ch_en = 2'b01; k = c + 2;
    expect_tick(0, k + 3 + LAT);
    wait_until(k + 2);
    check("oneshot_busy", 32'(busy[0]), 32'h1);
    wait_until(k + 6);
    check("oneshot_done", 32'(done[0]), 32'h1);
    check("oneshot_notbusy", 32'(busy[0]), 32'h0);
    wait_until(k + 10);
    ch_en = 2'b00;
    wait_until(k + 12);
    check("oneshot_done_clr", 32'(done[0]), 32'h0);
    ch_en = 2'b01; k2 = k + 13;
    expect_tick(0, k2 + 3 + LAT);
    wait_until(k2 + 6);
    check("oneshot_redone", 32'(done[0]), 32'h1);
    ch_en = 2'b00; ch_oneshot = 2'b00;
    step(3);

    // Period 0: continuous strobe
    c = cyc;
    write_period(1'b0, 26'd0);
    ch_en = 2'b01; k = c + 2;
    for (int t = k; t <= k + 9; t++) expect_tick(0, t + LAT);
    wait_until(k + 9);
    ch_en = 2'b00;
    wait_until(k + 10 + LAT);
    check("strobe_stop", 32'(tick[0]), 32'h0);
    step(2);

    // sync_clr with ch0 at cnt 7 and ch1 at terminal, both period 9
    write_period(1'b0, 26'd9);
    write_period(1'b1, 26'd9);
    c = cyc; ch_en = 2'b10;
    wait_until(c + 2);
    ch_en = 2'b11;
    wait_until(c + 10);
    sync_clr = 1'b1;
    #1;
    check("sync_no_tick", 32'(tick), 32'h0);
    step(1);
    sync_clr = 1'b0;
    for (int t = c + 20; t <= c + 30; t += 10) begin
      expect_tick(0, t + LAT);
      expect_tick(1, t + LAT);
    end
    wait_until(c + 32);
    ch_en = 2'b00;
    step(2);

    // Async reset mid-count reverts periods to defaults
    write_period(1'b0, 26'd5);
    write_period(1'b1, 26'd5);
    c = cyc; ch_en = 2'b11; k = c + 1;
    wait_until(k + 3);
    check("pre_rst_busy", 32'(busy), 32'h3);
    rstn = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    wait_until(k + 6);
    rstn = 1'b1; r = cyc;
    for (int t = r + 10; t <= r + 100; t += 10) expect_tick(0, t + LAT);
    expect_tick(1, r + 100 + LAT);
    wait_until(r + 105);
    ch_en = 2'b00;
    step(3);

    check("leftover_ticks", 32'(exp_tick.num()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
